// File: rtl/link_pulse_gen.sv
// link_pulse_gen: 10BASE-T NLP / FLP burst generator with post-burst go strobe
// Optional feature macro TX_BUSY_SUPPRESS_EN: hold off new bursts while tx_busy is high
module link_pulse_gen #(
    parameter int INTERVAL_CYC = 320000,
    parameter int PULSE_CYC    = 2,
    parameter int SLOT_CYC     = 1250,
    parameter int GO_DLY_CYC   = 30020,
    parameter int GO_LEN_CYC   = 10
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        en,
    input  logic        mode,
    input  logic [15:0] lcw,
    input  logic        tx_busy,
    output logic        tx,
    output logic        go,
    output logic        pulse_done
);
    localparam int TW   = $clog2(INTERVAL_CYC);
    localparam int SW   = $clog2(SLOT_CYC);
    localparam int GMAX = GO_DLY_CYC > GO_LEN_CYC ? GO_DLY_CYC : GO_LEN_CYC;
    localparam int GW   = $clog2(GMAX + 1);
    localparam bit DIRECT_GO = GO_DLY_CYC == PULSE_CYC;

    typedef enum logic [2:0] {IDLE, WAIT, PULSE, GAP, GODLY, GO} state_t;

    state_t          state, state_n;
    logic [TW-1:0]   tmr, tmr_n;
    logic [SW-1:0]   sc, sc_n;
    logic [5:0]      k, k_n;
    logic [GW-1:0]   gc, gc_n;
    logic            mode_l, mode_ln;
    logic [15:0]     lcw_l, lcw_ln;
    logic            tx_n, go_n, pd_n;
    logic            hold, wrap, ps;
    logic            pulse_end, slot_end;
    logic [5:0]      last_k;

`ifdef TX_BUSY_SUPPRESS_EN
    assign hold = tx_busy && (state == IDLE || state == WAIT);
`else
    logic unused_busy;
    assign unused_busy = tx_busy;
    assign hold = 1'b0;
`endif

    assign wrap      = tmr == TW'(INTERVAL_CYC - 1);
    assign ps        = en && !hold && wrap;
    assign pulse_end = sc == SW'(PULSE_CYC - 1);
    assign slot_end  = sc == SW'(SLOT_CYC - 1);
    assign last_k    = mode_l ? 6'd32 : 6'd0;

    // next-state, counters and registered-output values; en=0 overrides everything
    always_comb begin
        state_n = state;
        tmr_n   = (hold || wrap) ? '0 : tmr + 1'b1;
        sc_n    = sc + 1'b1;
        k_n     = k;
        gc_n    = gc + 1'b1;
        mode_ln = mode_l;
        lcw_ln  = lcw_l;
        pd_n    = 1'b0;
        case (state)
            IDLE:  state_n = WAIT;
            WAIT:  if (ps) begin
                       state_n = PULSE;
                       sc_n    = '0;
                       k_n     = '0;
                       mode_ln = mode;
                       lcw_ln  = lcw;
                   end
            PULSE: if (pulse_end) begin
                       if (k == last_k) begin
                           state_n = DIRECT_GO ? GO : GODLY;
                           gc_n    = DIRECT_GO ? '0 : GW'(PULSE_CYC);
                           pd_n    = 1'b1;
                       end else begin
                           state_n = GAP;
                       end
                   end
            GAP:   if (slot_end) begin
                       state_n = PULSE;
                       sc_n    = '0;
                       k_n     = k + 1'b1;
                   end
            GODLY: if (gc == GW'(GO_DLY_CYC - 1)) begin
                       state_n = GO;
                       gc_n    = '0;
                   end
            GO:    if (gc == GW'(GO_LEN_CYC - 1)) state_n = WAIT;
            default: state_n = IDLE;
        endcase
        if (!en) begin
            state_n = IDLE;
            tmr_n   = '0;
            sc_n    = '0;
            k_n     = '0;
            gc_n    = '0;
            pd_n    = 1'b0;
        end
        // even slots are clock pulses; odd slot 2i+1 carries lcw bit i
        tx_n = state_n == PULSE && (!mode_ln || !k_n[0] || lcw_ln[k_n[4:1]]);
        go_n = state_n == GO;
    end

    // state, counters, latched word and registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            tmr        <= '0;
            sc         <= '0;
            k          <= '0;
            gc         <= '0;
            mode_l     <= 1'b0;
            lcw_l      <= '0;
            tx         <= 1'b0;
            go         <= 1'b0;
            pulse_done <= 1'b0;
        end else begin
            state      <= state_n;
            tmr        <= tmr_n;
            sc         <= sc_n;
            k          <= k_n;
            gc         <= gc_n;
            mode_l     <= mode_ln;
            lcw_l      <= lcw_ln;
            tx         <= tx_n;
            go         <= go_n;
            pulse_done <= pd_n;
        end
    end
endmodule

// File: tb/tb_link_pulse_gen.sv
// tb_link_pulse_gen: scoreboard bench for link_pulse_gen with an event-list reference model
module tb_link_pulse_gen;
    localparam int INTERVAL = 400;
    localparam int PULSE    = 2;
    localparam int SLOT     = 8;
    localparam int GO_DLY   = 20;
    localparam int GO_LEN   = 3;
`ifdef TX_BUSY_SUPPRESS_EN
    localparam int BUSY_FIRST = 1000;
`else
    localparam int BUSY_FIRST = 400;
`endif

    typedef struct {
        int         cyc;
        logic [2:0] v;
    } ev_t;

    logic        clk = 1'b0;
    logic        resetn, en, mode, tx_busy;
    logic [15:0] lcw;
    logic        tx, go, pulse_done;
    int          gcyc = 0;
    int          tests = 0;
    int          fails = 0;
    ev_t         exp_q[$];
    ev_t         e;
    logic [2:0]  obs;

    link_pulse_gen #(
        .INTERVAL_CYC(INTERVAL),
        .PULSE_CYC(PULSE),
        .SLOT_CYC(SLOT),
        .GO_DLY_CYC(GO_DLY),
        .GO_LEN_CYC(GO_LEN)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .en(en),
        .mode(mode),
        .lcw(lcw),
        .tx_busy(tx_busy),
        .tx(tx),
        .go(go),
        .pulse_done(pulse_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) gcyc <= gcyc + 1;

    // monitor: every nonzero output cycle must match the front of the expectation queue
    always @(negedge clk) begin
        obs = {tx, go, pulse_done};
        if (exp_q.size() > 0 && exp_q[0].cyc == gcyc) begin
            e = exp_q.pop_front();
            tests++;
            if (obs !== e.v) begin
                fails++;
                $display("FAIL burst_out @%0d txgopd=%b want %b", gcyc, obs, e.v);
            end
        end else if (obs !== 3'b000) begin
            fails++;
            $display("FAIL spurious_out @%0d txgopd=%b want 000", gcyc, obs);
        end
    end

    // reference: one NLP or FLP burst starting at cycle s, truncated after cycle d
    task automatic push_burst(input int s, input bit md, input logic [15:0] w, input int d);
        logic [2:0] v [300];
        int   last;
        ev_t  x;
        for (int i = 0; i < 300; i++) v[i] = 3'b000;
        last = md ? 32 * SLOT : 0;
        for (int k = 0; k <= (md ? 32 : 0); k++)
            if (!md || k % 2 == 0 || w[(k - 1) / 2])
                for (int p = 0; p < PULSE; p++) v[k * SLOT + p][2] = 1'b1;
        v[last + PULSE][0] = 1'b1;
        for (int g = 0; g < GO_LEN; g++) v[last + GO_DLY + g][1] = 1'b1;
        for (int i = 0; i < 300; i++)
            if (v[i] != 3'b000 && s + i <= d) begin
                x.cyc = s + i;
                x.v   = v[i];
                exp_q.push_back(x);
            end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // en high for L cycles from now; bursts at first, first+INTERVAL, ...
    task automatic session(input int first, input int L, input bit rnd, input int chg_at,
                           input int bs, input int be, input bit rst_end);
        int n0, d, nps;
        n0  = gcyc;
        d   = n0 + L;
        nps = n0 + first;
        en  = 1'b1;
        for (int c = 1; c < L; c++) begin
            @(posedge clk);
            #1;
            if (gcyc == n0 + chg_at) begin
                mode = 1'b0;
                lcw  = 16'hFFFF;
            end
            if (gcyc == n0 + bs) tx_busy = 1'b1;
            if (gcyc == n0 + be) tx_busy = 1'b0;
            if (rnd && $urandom_range(0, 29) == 0) begin
                mode = 1'($urandom);
                lcw  = 16'($urandom);
            end
`ifndef TX_BUSY_SUPPRESS_EN
            if (rnd && $urandom_range(0, 49) == 0) tx_busy = ~tx_busy;
`endif
            if (gcyc == nps - 1) begin
                if (rnd && $urandom_range(0, 1) == 1) begin
                    mode = 1'($urandom);
                    lcw  = 16'($urandom);
                end
                push_burst(nps, mode, lcw, d);
                nps += INTERVAL;
            end
        end
        @(posedge clk);
        #1;
        if (rst_end) begin
            @(posedge clk);
            #1 resetn = 1'b0;
            #1;
            tests++;
            if ({tx, go, pulse_done} !== 3'b000) begin
                fails++;
                $display("FAIL async_reset txgopd=%b want 000", {tx, go, pulse_done});
            end
            @(posedge clk);
            #1 resetn = 1'b1;
        end else begin
            en = 1'b0;
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog expired at cycle %0d", gcyc);
        $fatal(1);
    end

    initial begin
        resetn  = 1'b0;
        en      = 1'b0;
        mode    = 1'b0;
        lcw     = 16'h0000;
        tx_busy = 1'b0;
        repeat (3) begin
            @(negedge clk);
            tests++;
            if ({tx, go, pulse_done} !== 3'b000) begin
                fails++;
                $display("FAIL reset_state txgopd=%b want 000", {tx, go, pulse_done});
            end
        end
        @(posedge clk);
        #1 resetn = 1'b1;
        idle(2);
        mode = 1'b0;
        session(400, 1000, 1'b0, -1, -1, -1, 1'b0);
        idle(5);
        mode = 1'b1;
        lcw  = 16'h8001;
        session(400, 900, 1'b0, 450, -1, -1, 1'b0);
        idle(5);
        mode = 1'b0;
        session(400, 401, 1'b0, -1, -1, -1, 1'b0);
        idle(99);
        session(400, 450, 1'b0, -1, -1, -1, 1'b0);
        idle(5);
        session(400, 420, 1'b0, -1, -1, -1, 1'b1);
        session(400, 500, 1'b0, -1, -1, -1, 1'b0);
        idle(5);
        session(BUSY_FIRST, 1300, 1'b0, -1, 100, 600, 1'b0);
        idle(5);
        repeat (8) begin
            mode = 1'($urandom);
            lcw  = 16'($urandom);
            session(400, $urandom_range(300, 1300), 1'b1, -1, -1, -1, 1'b0);
            tx_busy = 1'b0;
            idle($urandom_range(1, 50));
        end
        idle(300);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain pending=%0d want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
